// File: rtl/detector_ctrl_pkg.sv
// Shared types for the detector step controller: playback FSM states and the 2-bit {x,y} symbol.
package detector_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic x;
    logic y;
  } sym_t;

  localparam sym_t SYM_RESET = 2'b00;
  localparam sym_t SYM_X     = 2'b10;
  localparam sym_t SYM_XY    = 2'b11;

endpackage

// File: rtl/detector_step_controller_if.sv
// Step/match handshake between the step controller (master) and the sequence detector (slave).
interface detector_step_controller_if;

  logic step_valid;
  logic step_x;
  logic step_y;
  logic det_match;

  modport master (
    output step_valid,
    output step_x,
    output step_y,
    input  det_match
  );

  modport slave (
    input  step_valid,
    input  step_x,
    input  step_y,
    output det_match
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-high counter; emits one press pulse per hold of a raw button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic           sync_p0;
  logic           sync_p1;
  logic [CW-1:0]  count;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      count   <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // Any low sample restarts the stability window; saturation stops repeat pulses.
      if (!sync_p1)
        count <= '0;
      else if (count != CW'(DEBOUNCE_CYCLES))
        count <= count + 1'b1;
    end
  end

  assign press = sync_p1 && (count == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/detector_step_controller.sv
// Replays a loaded (x,y) symbol buffer to the sequence detector as paced step strobes and counts matches.
// Optional: define CONTINUOUS_LOOP_EN to wrap playback indefinitely instead of stopping in DONE.
module detector_step_controller
  import detector_ctrl_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_INTERVAL   = 4,
  parameter int CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sw_x,
  input  logic                     sw_y,
  input  logic                     btn_load,
  input  logic                     btn_run,
  input  logic                     btn_clear,
  detector_step_controller_if.master det,
  output logic [$clog2(DEPTH):0]   sym_count,
  output logic [CNT_W-1:0]         match_count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SC_W  = PTR_W + 1;
  localparam int TMR_W = $clog2(STEP_INTERVAL);

  logic load_p;
  logic run_p;
  logic clear_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_load),
    .press (load_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_run),
    .press (run_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (clear_p)
  );

  // Switch synchroniser stages (data only, no reset)
  logic sw_x_p0, sw_x_p1;
  logic sw_y_p0, sw_y_p1;

  always_ff @(posedge clk) begin
    sw_x_p0 <= sw_x;
    sw_x_p1 <= sw_x_p0;
    sw_y_p0 <= sw_y;
    sw_y_p1 <= sw_y_p0;
  end

  sym_t sym_in;
  assign sym_in = '{x: sw_x_p1, y: sw_y_p1};

  sym_t sym_mem [DEPTH];

  state_t             state, state_nxt;
  logic [SC_W-1:0]    rd_ptr, rd_ptr_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [SC_W-1:0]    sym_count_nxt;
  logic [CNT_W-1:0]   match_count_nxt;
  logic               overflow_nxt;
  logic               wr_en;
  logic               full;
  logic               last_sym;
  sym_t               cur_sym;

  assign full     = (sym_count == SC_W'(DEPTH));
  assign last_sym = ((rd_ptr + 1'b1) == sym_count);
  assign cur_sym  = sym_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en)
      sym_mem[sym_count[PTR_W-1:0]] <= sym_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      timer       <= '0;
      sym_count   <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_ptr      <= rd_ptr_nxt;
      timer       <= timer_nxt;
      sym_count   <= sym_count_nxt;
      match_count <= match_count_nxt;
      overflow    <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    rd_ptr_nxt      = rd_ptr;
    timer_nxt       = timer;
    sym_count_nxt   = sym_count;
    match_count_nxt = match_count;
    overflow_nxt    = overflow;
    wr_en           = 1'b0;
    det.step_valid  = 1'b0;
    {det.step_x, det.step_y} = SYM_RESET;
    busy            = 1'b0;
    done            = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        // Clear outranks load, load outranks run; a load from DONE drops back to IDLE.
        if (clear_p) begin
          sym_count_nxt   = '0;
          overflow_nxt    = 1'b0;
          match_count_nxt = '0;
          state_nxt       = IDLE;
        end else if (load_p) begin
          state_nxt = IDLE;
          if (full) begin
            overflow_nxt = 1'b1;
          end else begin
            wr_en         = 1'b1;
            sym_count_nxt = sym_count + 1'b1;
          end
        end else if (run_p && (sym_count != '0)) begin
          match_count_nxt = '0;
          rd_ptr_nxt      = '0;
          state_nxt       = ISSUE;
        end
      end

      ISSUE: begin
        busy           = 1'b1;
        det.step_valid = 1'b1;
        {det.step_x, det.step_y} = cur_sym;
        timer_nxt      = '0;
        state_nxt      = run_p ? IDLE : WAIT;
      end

      WAIT: begin
        busy = 1'b1;
        if ((timer == '0) && det.det_match && (match_count != '1))
          match_count_nxt = match_count + 1'b1;
        timer_nxt = timer + 1'b1;
        if (run_p) begin
          state_nxt = IDLE;
        end else if (timer == TMR_W'(STEP_INTERVAL - 2)) begin
          if (last_sym) begin
`ifdef CONTINUOUS_LOOP_EN
            rd_ptr_nxt = '0;
            state_nxt  = ISSUE;
`else
            state_nxt  = DONE;
`endif
          end else begin
            rd_ptr_nxt = rd_ptr + 1'b1;
            state_nxt  = ISSUE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_detector_step_controller.sv
// Randomized self-checking bench for detector_step_controller against a queue-based playback model.
module tb_detector_step_controller;

  localparam int DEPTH   = 8;
  localparam int DEB     = 4;
  localparam int SI      = 4;
  localparam int CNT_W   = 8;
  localparam int B_LOAD  = 0;
  localparam int B_RUN   = 1;
  localparam int B_CLEAR = 2;
  localparam int B_LDCLR = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_x = 1'b0, sw_y = 1'b0;
  logic btn_load = 1'b0, btn_run = 1'b0, btn_clear = 1'b0;
  logic [$clog2(DEPTH):0] sym_count;
  logic [CNT_W-1:0]       match_count;
  logic busy, done, overflow;

  detector_step_controller_if det_bus ();

  detector_step_controller #(
    .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .STEP_INTERVAL(SI), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .sw_x(sw_x), .sw_y(sw_y),
    .btn_load(btn_load), .btn_run(btn_run), .btn_clear(btn_clear),
    .det(det_bus), .sym_count(sym_count), .match_count(match_count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Strobe log and detector stand-in
  logic [1:0]  strobes[$];
  int          scyc[$];
  int          cyc = 0;
  int          sidx = 0;
  logic        pend = 1'b0;
  logic [31:0] mask = '0;
  int          idle_bad = 0;

  // Reference model: buffer contents and sticky overflow
  logic [1:0]  model_q[$];
  logic        exp_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    det_bus.det_match = pend;
    pend = 1'b0;
    if (det_bus.step_valid === 1'b1) begin
      strobes.push_back({det_bus.step_x, det_bus.step_y});
      scyc.push_back(cyc);
      pend = (sidx < 32) ? mask[sidx] : 1'b0;
      sidx++;
    end else if ((det_bus.step_x | det_bus.step_y) !== 1'b0) begin
      idle_bad++;
    end
  end

  task automatic clear_log();
    strobes.delete();
    scyc.delete();
    sidx = 0;
  endtask

  task automatic press(input int which, input int hold);
    @(negedge clk);
    case (which)
      B_LOAD:  btn_load = 1'b1;
      B_RUN:   btn_run = 1'b1;
      B_CLEAR: btn_clear = 1'b1;
      default: begin btn_load = 1'b1; btn_clear = 1'b1; end
    endcase
    repeat (hold) @(negedge clk);
    btn_load = 1'b0; btn_run = 1'b0; btn_clear = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic load_sym(input logic [1:0] s);
    @(negedge clk);
    sw_x = s[1]; sw_y = s[0];
    repeat (3) @(negedge clk);
    press(B_LOAD, 10);
    if (model_q.size() < DEPTH) model_q.push_back(s);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_clear();
    press(B_CLEAR, 10);
    model_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    if (sym_count !== '0) $display("FAIL reset_sym_count: got %0d want 0", sym_count); else passed++; total++;
    if (match_count !== '0) $display("FAIL reset_match_count: got %0d want 0", match_count); else passed++; total++;
    if ({busy, done, overflow} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); else passed++; total++;
    if (det_bus.step_valid !== 1'b0) $display("FAIL reset_step_valid: got %b want 0", det_bus.step_valid); else passed++; total++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    do_clear();
    load_sym(2'b10); load_sym(2'b10); load_sym(2'b11);
    clear_log();
    mask = 32'b100;
    press(B_RUN, 10);
    wait_idle(ok);
    if (!ok) $display("FAIL basic_timeout: busy stuck, want idle"); else passed++; total++;
    if (strobes.size() != 3) $display("FAIL basic_strobes: got %0d want 3", strobes.size()); else passed++; total++;
    for (int i = 0; i < strobes.size() && i < 3; i++) begin
      if (strobes[i] !== model_q[i]) $display("FAIL basic_sym%0d: got %b want %b", i, strobes[i], model_q[i]); else passed++; total++;
      if (i > 0) begin
        if (scyc[i] - scyc[i-1] != SI) $display("FAIL basic_gap%0d: got %0d want %0d", i, scyc[i] - scyc[i-1], SI); else passed++; total++;
      end
    end
    if (match_count !== 8'd1) $display("FAIL basic_match: got %0d want 1", match_count); else passed++; total++;
    if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else passed++; total++;
    if (sym_count !== 4'd3) $display("FAIL basic_sym_count: got %0d want 3", sym_count); else passed++; total++;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] m;
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) load_sym(2'($urandom_range(0, 3)));
    if (sym_count !== 4'(DEPTH)) $display("FAIL ovf_sym_count: got %0d want %0d", sym_count, DEPTH); else passed++; total++;
    if (overflow !== exp_ovf) $display("FAIL ovf_flag: got %b want %b", overflow, exp_ovf); else passed++; total++;
    clear_log();
    mask = $urandom;
    press(B_RUN, 10);
    wait_idle(ok);
    if (!ok) $display("FAIL ovf_timeout: busy stuck, want idle"); else passed++; total++;
    if (strobes.size() != model_q.size()) $display("FAIL ovf_strobes: got %0d want %0d", strobes.size(), model_q.size()); else passed++; total++;
    for (int i = 0; i < strobes.size() && i < model_q.size(); i++)
      if (strobes[i] !== model_q[i]) begin $display("FAIL ovf_sym%0d: got %b want %b", i, strobes[i], model_q[i]); total++; end
      else begin passed++; total++; end
    m = mask & 32'hFF;
    if (match_count !== 8'($countones(m))) $display("FAIL ovf_match: got %0d want %0d", match_count, $countones(m)); else passed++; total++;
    do_clear();
    if (sym_count !== '0) $display("FAIL clr_sym_count: got %0d want 0", sym_count); else passed++; total++;
    if ({overflow, done} !== 2'b00) $display("FAIL clr_flags: got %b want 00", {overflow, done}); else passed++; total++;
    if (match_count !== '0) $display("FAIL clr_match: got %0d want 0", match_count); else passed++; total++;
  endtask

  task automatic test_empty_run();
    clear_log();
    press(B_RUN, 10);
    repeat (20) @(negedge clk);
    if (strobes.size() != 0) $display("FAIL empty_strobes: got %0d want 0", strobes.size()); else passed++; total++;
    if ({busy, done} !== 2'b00) $display("FAIL empty_flags: got %b want 00", {busy, done}); else passed++; total++;
  endtask

  task automatic test_random_replay();
    bit ok;
    int n;
    logic [31:0] m;
    for (int it = 0; it < 3; it++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load_sym(2'($urandom_range(0, 3)));
      mask = $urandom;
      m = mask & ((32'd1 << n) - 1);
      for (int rep = 0; rep < 2; rep++) begin
        clear_log();
        press(B_RUN, 10);
        wait_idle(ok);
        if (!ok) $display("FAIL rnd_timeout: busy stuck, want idle"); else passed++; total++;
        if (strobes.size() != n) $display("FAIL rnd_strobes: got %0d want %0d", strobes.size(), n); else passed++; total++;
        for (int i = 0; i < strobes.size() && i < n; i++) begin
          if (strobes[i] !== model_q[i]) begin $display("FAIL rnd_sym%0d: got %b want %b", i, strobes[i], model_q[i]); total++; end
          else begin passed++; total++; end
          if (i > 0) begin
            if (scyc[i] - scyc[i-1] != SI) begin $display("FAIL rnd_gap%0d: got %0d want %0d", i, scyc[i] - scyc[i-1], SI); total++; end
            else begin passed++; total++; end
          end
        end
        if (match_count !== 8'($countones(m))) $display("FAIL rnd_match: got %0d want %0d", match_count, $countones(m)); else passed++; total++;
        if (done !== 1'b1) $display("FAIL rnd_done: got %b want 1", done); else passed++; total++;
      end
    end
  endtask

  task automatic test_abort();
    bit seen;
    do_clear();
    for (int i = 0; i < 4; i++) load_sym(2'($urandom_range(0, 3)));
    clear_log();
    mask = 32'b1;
    seen = 1'b0;
    @(negedge clk);
    btn_run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (det_bus.step_valid === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) $display("FAIL abort_first_strobe: got 0 strobes want 1"); else passed++; total++;
    // Release for one cycle, then press again so the stop lands between strobes 2 and 3.
    btn_run = 1'b0;
    @(negedge clk);
    btn_run = 1'b1;
    repeat (10) @(negedge clk);
    btn_run = 1'b0;
    repeat (20) @(negedge clk);
    if (strobes.size() != 2) $display("FAIL abort_strobes: got %0d want 2", strobes.size()); else passed++; total++;
    if ({busy, done} !== 2'b00) $display("FAIL abort_flags: got %b want 00", {busy, done}); else passed++; total++;
    if (match_count !== 8'd1) $display("FAIL abort_match_kept: got %0d want 1", match_count); else passed++; total++;
  endtask

  task automatic test_bounce();
    do_clear();
    @(negedge clk);
    sw_x = 1'b1; sw_y = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      btn_load = 1'b1;
      repeat (2) @(negedge clk);
      btn_load = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    if (sym_count !== '0) $display("FAIL bounce_no_load: got %0d want 0", sym_count); else passed++; total++;
    load_sym(2'($urandom_range(0, 3)));
    if (sym_count !== 4'd1) $display("FAIL bounce_one_load: got %0d want 1", sym_count); else passed++; total++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_sym(2'b10); load_sym(2'b11);
    clear_log();
    mask = '0;
    seen = 1'b0;
    @(negedge clk);
    btn_run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (det_bus.step_valid === 1'b1) begin seen = 1'b1; break; end
    end
    btn_run = 1'b0;
    if (!seen) $display("FAIL rstmid_strobe: got 0 strobes want 1"); else passed++; total++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if ({busy, done, overflow, det_bus.step_valid} !== 4'b0000) $display("FAIL rstmid_flags: got %b want 0000", {busy, done, overflow, det_bus.step_valid}); else passed++; total++;
    if (sym_count !== '0) $display("FAIL rstmid_sym_count: got %0d want 0", sym_count); else passed++; total++;
    if (match_count !== '0) $display("FAIL rstmid_match: got %0d want 0", match_count); else passed++; total++;
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
    clear_log();
    repeat (30) @(negedge clk);
    if (strobes.size() != 0) $display("FAIL rstmid_no_strobes: got %0d want 0", strobes.size()); else passed++; total++;
    load_sym(2'b10);
    if (sym_count !== 4'd1) $display("FAIL ldclr_pre: got %0d want 1", sym_count); else passed++; total++;
    press(B_LDCLR, 10);
    model_q.delete();
    if (sym_count !== '0) $display("FAIL ldclr_clear_wins: got %0d want 0", sym_count); else passed++; total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_run();
    test_random_replay();
    test_abort();
    test_bounce();
    test_reset_mid();
    if (idle_bad != 0) $display("FAIL idle_symbol_zero: got %0d nonzero cycles want 0", idle_bad); else passed++; total++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
